// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, widths, NOP word.
package hazard_ctrl_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned INSN_W   = 32;

  localparam logic [INSN_W-1:0] NOP_INSN = '0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_REDIRECT  = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus: pipeline status in, PC/pipeline-register control out.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 32
);
  logic [REG_W-1:0] ID_rs1;
  logic [REG_W-1:0] ID_rs2;
  logic [REG_W-1:0] EX_rd;
  logic             EX_MemRead;
  logic             branch_taken;
  logic [XLEN-1:0]  branch_target;
  logic             imem_ready;
  logic             dmem_busy;

  logic             PC_write;
  logic             PC_sel;
  logic [XLEN-1:0]  PC_target;
  logic             IF_ID_stall;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             back_stall;
  logic [CNT_W-1:0] stall_cycles;
  logic             timeout_err;

  modport master (
    output ID_rs1, ID_rs2, EX_rd, EX_MemRead, branch_taken, branch_target,
           imem_ready, dmem_busy,
    input  PC_write, PC_sel, PC_target, IF_ID_stall, IF_ID_flush, ID_EX_bubble,
           back_stall, stall_cycles, timeout_err
  );

  modport slave (
    input  ID_rs1, ID_rs2, EX_rd, EX_MemRead, branch_taken, branch_target,
           imem_ready, dmem_busy,
    output PC_write, PC_sel, PC_target, IF_ID_stall, IF_ID_flush, ID_EX_bubble,
           back_stall, stall_cycles, timeout_err
  );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use hazard detection: a load in EX writes a register the ID instruction reads.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_memread,
  output logic             o_load_use_c
);
  logic w_rd_nonzero;

  assign w_rd_nonzero = (i_ex_rd != '0);
  assign o_load_use_c = i_ex_memread && w_rd_nonzero &&
                        ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, deferred redirects, wait timeout, stall statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 32
)(
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned WCNT_W = $clog2(WAIT_LIMIT + 1);
  localparam int unsigned WCNT_X = WCNT_W + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_pend;
  logic [XLEN-1:0]   r_target;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_load_use;
  logic              w_latch;
  logic              w_pc_write;
  logic              w_pc_sel;
  logic [XLEN-1:0]   w_pc_target;
  logic              w_if_stall;
  logic              w_if_flush;
  logic              w_bubble;
  logic              w_back_stall;
  logic              w_in_wait;
  logic              w_nxt_wait;
  logic [WCNT_X-1:0] w_wcnt_inc;

  hazard_detect u_detect (
    .i_id_rs1     (bus.ID_rs1),
    .i_id_rs2     (bus.ID_rs2),
    .i_ex_rd      (bus.EX_rd),
    .i_ex_memread (bus.EX_MemRead),
    .o_load_use_c (w_load_use)
  );

  // Next state and combinational pipeline controls
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_pc_write   = 1'b1;
    w_pc_sel     = 1'b0;
    w_pc_target  = '0;
    w_if_stall   = 1'b0;
    w_if_flush   = 1'b0;
    w_bubble     = 1'b0;
    w_back_stall = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.dmem_busy) begin
          w_back_stall = 1'b1;
          w_if_stall   = 1'b1;
          w_pc_write   = 1'b0;
          w_latch      = bus.branch_taken && !r_pend;
          w_state_nxt  = ST_DMEM_WAIT;
        end else if (bus.branch_taken) begin
          w_pc_sel    = 1'b1;
          w_pc_target = bus.branch_target;
          w_if_flush  = 1'b1;
          w_bubble    = 1'b1;
        end else if (w_load_use) begin
          w_pc_write = 1'b0;
          w_if_stall = 1'b1;
          w_bubble   = 1'b1;
        end else if (!bus.imem_ready) begin
          w_pc_write  = 1'b0;
          w_if_flush  = 1'b1;
          w_state_nxt = ST_IMEM_WAIT;
        end
      end
      ST_DMEM_WAIT: begin
        if (bus.dmem_busy) begin
          w_back_stall = 1'b1;
          w_if_stall   = 1'b1;
          w_pc_write   = 1'b0;
          w_latch      = bus.branch_taken && !r_pend;
        end else begin
          w_state_nxt = r_pend ? ST_REDIRECT : ST_RUN;
        end
      end
      ST_IMEM_WAIT: begin
        if (bus.branch_taken) begin
          w_pc_sel    = 1'b1;
          w_pc_target = bus.branch_target;
          w_if_flush  = 1'b1;
          w_bubble    = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (!bus.imem_ready) begin
          w_pc_write = 1'b0;
          w_if_flush = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_pc_sel    = 1'b1;
        w_pc_target = r_target;
        w_if_flush  = 1'b1;
        w_bubble    = 1'b1;
        w_state_nxt = ST_RUN;
      end
    endcase
    if (w_if_flush) w_if_stall = 1'b0;
    // Reset forces the free-running pipeline controls regardless of state
    if (reset) begin
      w_state_nxt  = ST_RUN;
      w_latch      = 1'b0;
      w_pc_write   = 1'b1;
      w_pc_sel     = 1'b0;
      w_pc_target  = '0;
      w_if_stall   = 1'b0;
      w_if_flush   = 1'b0;
      w_bubble     = 1'b0;
      w_back_stall = 1'b0;
    end
  end

  assign w_in_wait  = (r_state == ST_DMEM_WAIT) || (r_state == ST_IMEM_WAIT);
  assign w_nxt_wait = (w_state_nxt == ST_DMEM_WAIT) || (w_state_nxt == ST_IMEM_WAIT);
  assign w_wcnt_inc = {1'b0, r_wcnt} + WCNT_X'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pend      <= 1'b0;
      r_target    <= '0;
      r_wcnt      <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_pend   <= 1'b1;
        r_target <= bus.branch_target;
      end else if (r_state == ST_REDIRECT) begin
        r_pend <= 1'b0;
      end
      // Wait counter saturates at the limit; the error flag is sticky
      if (w_in_wait) begin
        if (w_wcnt_inc >= WCNT_X'(WAIT_LIMIT)) r_timeout <= 1'b1;
        if (!w_nxt_wait)                            r_wcnt <= '0;
        else if (w_wcnt_inc >= WCNT_X'(WAIT_LIMIT)) r_wcnt <= WCNT_W'(WAIT_LIMIT);
        else                                        r_wcnt <= WCNT_W'(w_wcnt_inc);
      end else begin
        r_wcnt <= '0;
      end
      if (!w_pc_write && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.PC_write     = w_pc_write;
  assign bus.PC_sel       = w_pc_sel;
  assign bus.PC_target    = w_pc_target;
  assign bus.IF_ID_stall  = w_if_stall;
  assign bus.IF_ID_flush  = w_if_flush;
  assign bus.ID_EX_bubble = w_bubble;
  assign bus.back_stall   = w_back_stall;
  assign bus.stall_cycles = r_stall_cnt;
  assign bus.timeout_err  = r_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic checked against a behavioural model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int unsigned WL = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(64), .CNT_W(32)) if0 ();
  hazard_ctrl_if #(.XLEN(64), .CNT_W(4))  if1 ();

  hazard_ctrl #(.XLEN(64), .WAIT_LIMIT(WL), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  hazard_ctrl #(.XLEN(64), .WAIT_LIMIT(WL), .CNT_W(4))  dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic [4:0]  t_rs1, t_rs2, t_rd;
  logic        t_mr, t_bt, t_ir, t_db;
  logic [63:0] t_tgt;

  assign if0.ID_rs1 = t_rs1;        assign if1.ID_rs1 = t_rs1;
  assign if0.ID_rs2 = t_rs2;        assign if1.ID_rs2 = t_rs2;
  assign if0.EX_rd = t_rd;          assign if1.EX_rd = t_rd;
  assign if0.EX_MemRead = t_mr;     assign if1.EX_MemRead = t_mr;
  assign if0.branch_taken = t_bt;   assign if1.branch_taken = t_bt;
  assign if0.branch_target = t_tgt; assign if1.branch_target = t_tgt;
  assign if0.imem_ready = t_ir;     assign if1.imem_ready = t_ir;
  assign if0.dmem_busy = t_db;      assign if1.dmem_busy = t_db;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pipeline mode, pending redirect, wait run length, stall tally
  localparam int M_RUN = 0, M_DWAIT = 1, M_IWAIT = 2, M_REDIR = 3;
  localparam int A_NONE = 0, A_BACK = 1, A_REDIR = 2, A_LU = 3, A_FETCH = 4;

  typedef struct packed {
    logic        pw;
    logic        ps;
    logic [63:0] pt;
    logic        st;
    logic        fl;
    logic        bb;
    logic        bs;
  } exp_t;

  int          m_mode  = M_RUN;
  logic        m_pend  = 1'b0;
  logic [63:0] m_tgt   = '0;
  int          m_run   = 0;
  logic        m_to    = 1'b0;
  longint      m_stall = 0;

  function automatic exp_t act_out(input int act, input logic [63:0] tgt);
    exp_t e;
    e = '0;
    e.pw = 1'b1;
    case (act)
      A_BACK:  begin e.pw = 1'b0; e.st = 1'b1; e.bs = 1'b1; end
      A_REDIR: begin e.ps = 1'b1; e.pt = tgt; e.fl = 1'b1; e.bb = 1'b1; end
      A_LU:    begin e.pw = 1'b0; e.st = 1'b1; e.bb = 1'b1; end
      A_FETCH: begin e.pw = 1'b0; e.fl = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic model_step();
    exp_t        e;
    int          act, nmode;
    logic        lu, want_latch;
    logic [63:0] tg, s0, s1;
    lu = t_mr && (t_rd != 5'd0) && ((t_rd == t_rs1) || (t_rd == t_rs2));
    act = A_NONE; tg = t_tgt; nmode = m_mode; want_latch = 1'b0;
    if (!reset) begin
      if (m_mode == M_RUN) begin
        if (t_db)       begin act = A_BACK; nmode = M_DWAIT; want_latch = t_bt; end
        else if (t_bt)  act = A_REDIR;
        else if (lu)    act = A_LU;
        else if (!t_ir) begin act = A_FETCH; nmode = M_IWAIT; end
      end else if (m_mode == M_DWAIT) begin
        if (t_db) begin act = A_BACK; want_latch = t_bt; end
        else nmode = m_pend ? M_REDIR : M_RUN;
      end else if (m_mode == M_IWAIT) begin
        if (t_bt)       begin act = A_REDIR; nmode = M_RUN; end
        else if (!t_ir) act = A_FETCH;
        else            nmode = M_RUN;
      end else begin
        act = A_REDIR; tg = m_tgt; nmode = M_RUN;
      end
    end
    e  = act_out(act, tg);
    s0 = (m_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(m_stall);
    s1 = (m_stall > 15) ? 64'd15 : 64'(m_stall);

    chk("pc_write0", 64'(if0.PC_write), 64'(e.pw));
    chk("pc_sel0", 64'(if0.PC_sel), 64'(e.ps));
    chk("pc_target0", if0.PC_target, e.pt);
    chk("if_stall0", 64'(if0.IF_ID_stall), 64'(e.st));
    chk("if_flush0", 64'(if0.IF_ID_flush), 64'(e.fl));
    chk("bubble0", 64'(if0.ID_EX_bubble), 64'(e.bb));
    chk("back_stall0", 64'(if0.back_stall), 64'(e.bs));
    chk("stall_cnt0", 64'(if0.stall_cycles), s0);
    chk("timeout0", 64'(if0.timeout_err), 64'(m_to));
    chk("pc_write1", 64'(if1.PC_write), 64'(e.pw));
    chk("pc_target1", if1.PC_target, e.pt);
    chk("if_stall1", 64'(if1.IF_ID_stall), 64'(e.st));
    chk("if_flush1", 64'(if1.IF_ID_flush), 64'(e.fl));
    chk("back_stall1", 64'(if1.back_stall), 64'(e.bs));
    chk("stall_cnt1", 64'(if1.stall_cycles), s1);
    chk("timeout1", 64'(if1.timeout_err), 64'(m_to));

    if (reset) begin
      m_mode = M_RUN; m_pend = 1'b0; m_tgt = '0; m_run = 0; m_to = 1'b0; m_stall = 0;
    end else begin
      if (!e.pw) m_stall++;
      if (m_mode == M_DWAIT || m_mode == M_IWAIT) begin
        m_run++;
        if (m_run >= int'(WL)) m_to = 1'b1;
        if (nmode != M_DWAIT && nmode != M_IWAIT) m_run = 0;
      end else begin
        m_run = 0;
      end
      if (want_latch && !m_pend) begin m_pend = 1'b1; m_tgt = t_tgt; end
      else if (m_mode == M_REDIR) m_pend = 1'b0;
      m_mode = nmode;
    end
  endtask

  task automatic idle();
    t_rs1 = '0; t_rs2 = '0; t_rd = '0; t_mr = 1'b0;
    t_bt = 1'b0; t_tgt = '0; t_ir = 1'b1; t_db = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    model_step();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    settle();
    chk("rst_pc_write", 64'(if0.PC_write), 64'd1);
    chk("rst_pc_target", if0.PC_target, 64'd0);
    chk("rst_stall_cnt", 64'(if0.stall_cycles), 64'd0);
    next();

    reset = 1'b0;
    settle(); next();

    // Load-use against rs2, then the same with rd = x0
    t_mr = 1'b1; t_rd = 5'd5; t_rs2 = 5'd5;
    settle();
    chk("lu_pc_write", 64'(if0.PC_write), 64'd0);
    chk("lu_if_stall", 64'(if0.IF_ID_stall), 64'd1);
    chk("lu_bubble", 64'(if0.ID_EX_bubble), 64'd1);
    next();
    t_rd = 5'd0;
    settle();
    chk("lu_x0_pc_write", 64'(if0.PC_write), 64'd1);
    chk("lu_x0_if_stall", 64'(if0.IF_ID_stall), 64'd0);
    next();

    // Taken branch in RUN
    idle(); t_bt = 1'b1; t_tgt = 64'h100;
    settle();
    chk("br_pc_sel", 64'(if0.PC_sel), 64'd1);
    chk("br_pc_target", if0.PC_target, 64'h100);
    chk("br_flush", 64'(if0.IF_ID_flush), 64'd1);
    chk("br_bubble", 64'(if0.ID_EX_bubble), 64'd1);
    next();

    // Deferred branch: busy 3 cycles, branch in the 2nd, a later one ignored
    idle(); t_db = 1'b1;
    settle(); chk("dfr_back1", 64'(if0.back_stall), 64'd1); next();
    t_bt = 1'b1; t_tgt = 64'h200;
    settle(); chk("dfr_back2", 64'(if0.back_stall), 64'd1); next();
    t_tgt = 64'h300;
    settle(); chk("dfr_back3", 64'(if0.back_stall), 64'd1); next();
    idle();
    settle();
    chk("dfr_release_back", 64'(if0.back_stall), 64'd0);
    chk("dfr_release_sel", 64'(if0.PC_sel), 64'd0);
    next();
    settle();
    chk("dfr_redir_sel", 64'(if0.PC_sel), 64'd1);
    chk("dfr_redir_target", if0.PC_target, 64'h200);
    chk("dfr_redir_flush", 64'(if0.IF_ID_flush), 64'd1);
    next();
    settle();
    chk("dfr_after_sel", 64'(if0.PC_sel), 64'd0);
    next();

    // Instruction-memory timeout, stall tally and 4-bit saturation
    reset = 1'b1; settle(); next();
    reset = 1'b0; t_ir = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk("to_stall_cnt", 64'(if0.stall_cycles), 64'(i));
      chk("to_flag", 64'(if0.timeout_err), (i >= 16) ? 64'd1 : 64'd0);
      next();
    end
    t_ir = 1'b1;
    settle();
    chk("to_stall_total", 64'(if0.stall_cycles), 64'd20);
    chk("sat_stall_total", 64'(if1.stall_cycles), 64'd15);
    next();
    settle();
    chk("to_sticky", 64'(if0.timeout_err), 64'd1);
    next();

    // Reset in DMEM_WAIT with a pending redirect
    t_db = 1'b1;
    settle(); next();
    t_bt = 1'b1; t_tgt = 64'h400;
    settle(); next();
    reset = 1'b1;
    settle();
    chk("rstw_pc_write", 64'(if0.PC_write), 64'd1);
    chk("rstw_back", 64'(if0.back_stall), 64'd0);
    next();
    reset = 1'b0; idle();
    settle();
    chk("rstw_stall_cnt", 64'(if0.stall_cycles), 64'd0);
    chk("rstw_timeout", 64'(if0.timeout_err), 64'd0);
    next();
    settle();
    chk("rstw_no_redir", 64'(if0.PC_sel), 64'd0);
    next();

    // Random traffic with periodic long memory waits
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      t_mr  = 1'($urandom_range(1));
      t_rd  = 5'($urandom_range(3));
      t_rs1 = 5'($urandom_range(3));
      t_rs2 = 5'($urandom_range(3));
      t_tgt = {$urandom, $urandom};
      t_bt  = ($urandom_range(5) == 0);
      t_db  = ($urandom_range(3) == 0);
      t_ir  = ($urandom_range(3) != 0);
      if ((i % 250) < 20) begin
        t_ir = 1'b0; t_bt = 1'b0; t_db = 1'b0;
      end else if ((i % 250) >= 100 && (i % 250) < 120) begin
        t_db = 1'b1;
      end
      settle();
      next();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter XLEN, default 64: PC and branch-target width.
REQ-002 Parameter WAIT_LIMIT, default 15: maximum consecutive memory-wait cycles before timeout_err is set.
REQ-003 Parameter CNT_W, default 32: stall_cycles counter width.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 ID_rs1, ID_rs2  in  5 each: source registers of the instruction in ID.
REQ-007 EX_rd  in  5: destination register of the instruction in EX.
REQ-008 EX_MemRead  in  1: the EX instruction is a load.
REQ-009 branch_taken  in  1: a branch or jump resolved taken in EX this cycle.
REQ-010 branch_target  in  XLEN: redirect address, valid when branch_taken=1.
REQ-011 imem_ready  in  1: instruction memory returns a valid fetch this cycle.
REQ-012 dmem_busy  in  1: data memory cannot accept or complete an access this cycle.
REQ-013 PC_write  out  1: PC register update enable.
REQ-014 PC_sel  out  1: 1 selects PC_target; 0 selects PC+4.
REQ-015 PC_target  out  XLEN: redirect address.
REQ-016 IF_ID_stall  out  1: holds the IF/ID register.
REQ-017 IF_ID_flush  out  1: loads a NOP (all-zero) into IF/ID.
REQ-018 ID_EX_bubble  out  1: injects a bubble into ID/EX.
REQ-019 back_stall  out  1: freezes ID/EX, EX/MEM and MEM/WB.
REQ-020 stall_cycles  out  CNT_W: count of cycles with PC_write=0.
REQ-021 timeout_err  out  1: sticky memory-wait timeout flag.

Function
REQ-022 States SHALL be RUN, DMEM_WAIT, IMEM_WAIT and REDIRECT; outputs SHALL be combinational from state and inputs.
REQ-023 Load-use SHALL be detected when EX_MemRead=1, EX_rd!=0, and EX_rd equals ID_rs1 or ID_rs2.
REQ-024 In RUN the priority SHALL be dmem_busy > branch_taken > load-use > !imem_ready.
REQ-025 RUN with dmem_busy=1: back_stall=1, IF_ID_stall=1, PC_write=0; next state DMEM_WAIT.
REQ-026 RUN with branch_taken=1 (no dmem_busy): PC_sel=1, PC_target=branch_target, PC_write=1, IF_ID_flush=1, ID_EX_bubble=1; next state RUN.
REQ-027 RUN with load-use (no higher-priority event): PC_write=0, IF_ID_stall=1, ID_EX_bubble=1 for exactly one cycle; next state RUN.
REQ-028 RUN with imem_ready=0 (no higher-priority event): PC_write=0, IF_ID_flush=1; next state IMEM_WAIT.
REQ-029 DMEM_WAIT SHALL assert back_stall=1, IF_ID_stall=1 and PC_write=0 while dmem_busy=1, and SHALL return to RUN (or to REDIRECT if a redirect is pending) in the cycle after dmem_busy=0.
REQ-030 A branch_taken seen while dmem_busy=1, in RUN or DMEM_WAIT, SHALL latch branch_target and a pending flag; the first latch wins and later ones are ignored.
REQ-031 IMEM_WAIT SHALL assert PC_write=0 and IF_ID_flush=1 while imem_ready=0, and SHALL return to RUN in the cycle imem_ready=1.
REQ-032 A branch_taken in IMEM_WAIT SHALL redirect immediately as in REQ-026 and move to RUN.
REQ-033 REDIRECT SHALL last one cycle: PC_sel=1, PC_target=latched target, PC_write=1, IF_ID_flush=1, ID_EX_bubble=1; the pending flag clears; next state RUN.
REQ-034 A wait counter SHALL increment each cycle spent in DMEM_WAIT or IMEM_WAIT and clear on leaving either state; reaching WAIT_LIMIT SHALL set timeout_err, which holds until reset with no change to state behaviour.
REQ-035 stall_cycles SHALL increment in every cycle with PC_write=0 and saturate at all-ones.
REQ-036 IF_ID_stall and IF_ID_flush SHALL never both be 1; flush SHALL take precedence.

Reset
REQ-037 A synchronous reset SHALL set state=RUN, clear the pending flag, latched target, wait counter, stall_cycles and timeout_err, and discard any pending redirect.
REQ-038 While reset=1 the outputs SHALL be PC_write=1, PC_sel=0, PC_target=0, and all stall, flush and bubble outputs 0.

Structure
REQ-039 The state encoding, NOP constant and XLEN default SHALL live in a shared pipeline package.
REQ-040 Load-use comparison SHALL be a sub-module hazard_detect (purely combinational); the FSM and counters stay in hazard_ctrl.

Verification
REQ-041 Load-use test: EX_MemRead=1, EX_rd=5, ID_rs2=5 -> one cycle of PC_write=0, IF_ID_stall=1, ID_EX_bubble=1; the same with EX_rd=0 -> no stall.
REQ-042 Branch test: branch_taken=1, target=0x100 in RUN -> same cycle PC_sel=1, PC_target=0x100, IF_ID_flush=1, ID_EX_bubble=1.
REQ-043 Deferred branch test: dmem_busy high for 3 cycles with branch_taken (target 0x200) in the 2nd cycle -> 3 cycles of back_stall, then one REDIRECT cycle to 0x200, then RUN.
REQ-044 Timeout test: imem_ready=0 for 20 cycles with WAIT_LIMIT=15 -> timeout_err rises after 15 wait cycles and stays 1; stall_cycles=20.
REQ-045 Reset test: reset asserted in DMEM_WAIT with a redirect pending -> next cycle RUN, no redirect issued, counters 0.
REQ-046 Saturation test: with CNT_W=4, hold a stall for 20 cycles -> stall_cycles stays at 15.
